// File: rtl/signed_mul_arbiter.sv
// Two-requester round-robin front end for a single sequential shift-add multiplier.
// Signed requests are multiplied as magnitudes; the sign is applied when the product is published.
module signed_mul_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    input  logic                 req0_signed,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    input  logic                 req1_signed,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [2*WIDTH-1:0]   rsp_prod
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // state | meaning
    // IDLE  | waiting for a request; grant is combinational
    // BUSY  | one shift-add iteration per cycle, WIDTH cycles
    // DONE  | product presented, held until rsp_ready
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state, state_nxt;
    logic                 last;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc, acc_nxt;
    logic [WIDTH-1:0]     mcand, mplier;
    logic                 neg, id;
    logic                 grant0, grant1, accept, last_iter;
    logic [WIDTH-1:0]     sel_a, sel_b;
    logic                 sel_signed;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
        return (s && v[WIDTH-1]) ? ((~v) + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
    endfunction

    always_comb begin
        state_nxt  = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        last_iter  = (cnt == CW'(WIDTH-1));
        case (state)
            IDLE: begin
                if (!rst) begin
                    // last==1 means requester 1 was served most recently, so 0 wins a tie
                    if (req0_valid && (!req1_valid || last))
                        grant0 = 1'b1;
                    else if (req1_valid)
                        grant1 = 1'b1;
                end
                if (grant0 || grant1)
                    state_nxt = BUSY;
            end
            BUSY: if (last_iter) state_nxt = DONE;
            DONE: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        accept     = grant0 | grant1;
        sel_a      = grant1 ? req1_a      : req0_a;
        sel_b      = grant1 ? req1_b      : req0_b;
        sel_signed = grant1 ? req1_signed : req0_signed;
        acc_nxt    = acc + (mplier[cnt] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_prod  <= '0;
            rsp_id    <= 1'b0;
            last      <= 1'b1;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            neg       <= 1'b0;
            id        <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand  <= mag(sel_a, sel_signed);
                        mplier <= mag(sel_b, sel_signed);
                        neg    <= sel_signed & (sel_a[WIDTH-1] ^ sel_b[WIDTH-1]);
                        id     <= grant1;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                BUSY: begin
                    acc <= acc_nxt;
                    cnt <= cnt + CW'(1);
                    if (last_iter) begin
                        // -0 folds back to 0, so 0 x -128 needs no special case
                        rsp_prod  <= neg ? (-acc_nxt) : acc_nxt;
                        rsp_valid <= 1'b1;
                        rsp_id    <= id;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        last      <= rsp_id;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_mul_arbiter.sv
// Self-checking bench for signed_mul_arbiter: directed vectors, corner sequences and
// a randomized run against an arithmetic reference with an in-order scoreboard.
module tb_signed_mul_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_signed;
    logic [7:0]  req0_a, req0_b;
    logic        req1_valid, req1_ready, req1_signed;
    logic [7:0]  req1_a, req1_b;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [15:0] rsp_prod;

    int checks = 0;
    int failures = 0;

    signed_mul_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_signed(req0_signed),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_signed(req1_signed),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_prod(rsp_prod)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         id;
        logic [7:0] a;
        logic [7:0] b;
        bit         s;
        logic [15:0] prod;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input bit s);
        int x;
        int y;
        int p;
        if (s) begin
            x = int'($signed(a));
            y = int'($signed(b));
        end else begin
            x = int'(a);
            y = int'(b);
        end
        p = x * y;
        return p[15:0];
    endfunction

    task automatic set_req(input bit id, input logic [7:0] a, input logic [7:0] b,
                           input bit s, input bit v);
        if (id) begin
            req1_a = a; req1_b = b; req1_signed = s; req1_valid = v;
        end else begin
            req0_a = a; req0_b = b; req0_signed = s; req0_valid = v;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Issue one request on its own, wait for the grant, then collect the response.
    task automatic issue_collect(input string name, input bit id, input logic [7:0] a,
                                 input logic [7:0] b, input bit s, input logic [15:0] exp,
                                 output int gw, output int lat);
        set_req(id, a, b, s, 1'b1);
        rsp_ready = 1'b1;
        gw = 0;
        @(negedge clk);
        while (!(id ? req1_ready : req0_ready) && gw < 40) begin
            @(negedge clk);
            gw++;
        end
        chk({name, "_grant"}, id ? req1_ready : req0_ready, 1);
        @(posedge clk);
        #1;
        set_req(id, a, b, s, 1'b0);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk({name, "_valid"}, rsp_valid, 1);
        chk({name, "_prod"}, rsp_prod, exp);
        chk({name, "_id"}, rsp_id, id);
        tick();
    endtask

    vec_t vecs[10];
    int   gw, lat, n;

    // randomized-run model state
    bit          hp[2];
    logic [7:0]  pa[2], pb[2];
    bit          ps[2], v[2];
    bit          busy_m, last_m, e0, e1;
    logic [15:0] qp[$];
    bit          qi[$];
    int          accepted, responses, cyc;

    initial begin
        // reset state, with both requesters asserting valid during reset
        rst = 1'b1;
        rsp_ready = 1'b0;
        set_req(0, 8'h12, 8'h34, 1'b0, 1'b1);
        set_req(1, 8'h56, 8'h78, 1'b0, 1'b1);
        tick();
        tick();
        @(negedge clk);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_prod", rsp_prod, 0);
        chk("rst_rsp_id", rsp_id, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // single unsigned max request: grant in cycle 0, response in cycle 9
        issue_collect("single", 0, 8'hFF, 8'hFF, 1'b0, 16'hFE01, gw, lat);
        chk("single_grant_cycle", gw, 0);
        chk("single_latency", lat, 9);

        // directed vectors, signed corners first
        vecs[0] = '{0, 8'hFF, 8'hFF, 1'b1, 16'h0001};
        vecs[1] = '{0, 8'h80, 8'h80, 1'b1, 16'h4000};
        vecs[2] = '{0, 8'h80, 8'h7F, 1'b1, 16'hC080};
        vecs[3] = '{0, 8'h00, 8'h80, 1'b1, 16'h0000};
        vecs[4] = '{1, 8'h7F, 8'h7F, 1'b1, 16'h3F01};
        vecs[5] = '{1, 8'h80, 8'hFF, 1'b1, 16'h0080};
        vecs[6] = '{1, 8'h05, 8'hFD, 1'b1, 16'hFFF1};
        vecs[7] = '{0, 8'h80, 8'h80, 1'b0, 16'h4000};
        vecs[8] = '{1, 8'h12, 8'h34, 1'b0, 16'h03A8};
        vecs[9] = '{1, 8'hFF, 8'h01, 1'b0, 16'h00FF};
        for (int i = 0; i < 10; i++) begin
            issue_collect($sformatf("vec%0d", i), vecs[i].id, vecs[i].a, vecs[i].b,
                          vecs[i].s, vecs[i].prod, gw, lat);
            chk($sformatf("vec%0d_latency", i), lat, 9);
        end

        // both valid continuously: grants alternate starting with requester 0
        do_reset();
        set_req(0, 8'h07, 8'h09, 1'b0, 1'b1);
        set_req(1, 8'hFD, 8'h05, 1'b1, 1'b1);
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n = 0;
            while (!rsp_valid && n < 40) begin
                tick();
                n++;
            end
            chk($sformatf("rr%0d_valid", i), rsp_valid, 1);
            chk($sformatf("rr%0d_id", i), rsp_id, i % 2);
            chk($sformatf("rr%0d_prod", i), rsp_prod, (i % 2) ? 16'hFFF1 : 16'h003F);
            if (i == 5) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            tick();
        end

        // back-pressure: hold DONE for 5 cycles with requester 1 waiting
        set_req(0, 8'h23, 8'h45, 1'b0, 1'b1);
        rsp_ready = 1'b0;
        n = 0;
        @(negedge clk);
        while (!req0_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("bp_grant0", req0_ready, 1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        set_req(1, 8'h81, 8'h02, 1'b1, 1'b1);
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_valid", k), rsp_valid, 1);
            chk($sformatf("bp%0d_prod", k), rsp_prod, 16'h096F);
            chk($sformatf("bp%0d_id", k), rsp_id, 0);
            chk($sformatf("bp%0d_ready1", k), req1_ready, 0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready1", req1_ready, 0);
        chk("bp_release_valid", rsp_valid, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_idle_ready1", req1_ready, 1);
        chk("bp_idle_valid", rsp_valid, 0);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        chk("bp_req1_prod", rsp_prod, 16'hFF02);
        chk("bp_req1_id", rsp_id, 1);
        tick();

        // reset in the 4th BUSY cycle abandons the operation
        set_req(0, 8'h11, 8'h11, 1'b0, 1'b1);
        n = 0;
        @(negedge clk);
        while (!req0_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("abort_grant0", req0_ready, 1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        set_req(1, 8'h06, 8'h07, 1'b0, 1'b1);
        @(negedge clk);
        chk("abort_rst_ready1", req1_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_rsp_prod", rsp_prod, 0);
        @(negedge clk);
        chk("abort_idle_ready1", req1_ready, 1);
        @(posedge clk);
        #1;
        req1_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk("abort_next_id", rsp_id, 1);
        chk("abort_next_prod", rsp_prod, 16'h002A);
        chk("abort_next_latency", lat, 9);
        tick();

        // randomized traffic against the scoreboard
        do_reset();
        busy_m = 1'b0;
        last_m = 1'b1;
        hp[0] = 1'b0;
        hp[1] = 1'b0;
        accepted = 0;
        responses = 0;
        cyc = 0;
        while ((accepted < 2000 || qp.size() > 0) && cyc < 60000) begin
            cyc++;
            @(posedge clk);
            #1;
            for (int j = 0; j < 2; j++) begin
                if (!hp[j]) begin
                    pa[j] = 8'($urandom);
                    pb[j] = 8'($urandom);
                    ps[j] = 1'($urandom);
                    hp[j] = 1'b1;
                end
                v[j] = hp[j] && (accepted < 2000) && ($urandom_range(0, 3) != 0);
                set_req(j[0], pa[j], pb[j], ps[j], v[j]);
            end
            rsp_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            e0 = !busy_m && v[0] && (!v[1] || last_m);
            e1 = !busy_m && v[1] && !e0;
            chk("rnd_ready0", req0_ready, e0);
            chk("rnd_ready1", req1_ready, e1);
            if (rsp_valid && rsp_ready) begin
                if (qp.size() == 0) begin
                    chk("rnd_extra_rsp", rsp_valid, 0);
                end else begin
                    chk("rnd_rsp_id", rsp_id, qi[0]);
                    chk("rnd_rsp_prod", rsp_prod, qp[0]);
                    last_m = qi[0];
                    void'(qi.pop_front());
                    void'(qp.pop_front());
                    busy_m = 1'b0;
                    responses++;
                end
            end
            if (e0 || e1) begin
                qi.push_back(e1);
                qp.push_back(ref_mul(pa[e1], pb[e1], ps[e1]));
                hp[e1] = 1'b0;
                busy_m = 1'b1;
                accepted++;
            end
        end
        chk("rnd_accepted", accepted, 2000);
        chk("rnd_responses", responses, 2000);
        chk("rnd_queue_empty", qp.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/signed_mul_arbiter.md
# signed_mul_arbiter

Shares one sequential shift-add multiplier between two requesters. Each request carries two 8-bit operands and a per-request signedness flag selecting two's-complement or unsigned interpretation. The block arbitrates round-robin, runs one multiply at a time, and returns the full-width product with the requester ID over a valid/ready response channel. It sits between operand-producing blocks that mix signed and unsigned 8-bit nets and the single multiply resource they share.

## Interface
- WIDTH, 8, operand width; product is 2*WIDTH bits.
- clk  input  1  rising-edge clock, sole clock domain.
- rst  input  1  reset; synchronous, active-high.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  input  WIDTH  requester 0 operands.
- req0_signed  input  1  1 = operands are two's complement; 0 = unsigned.
- req1_valid, req1_ready, req1_a, req1_b, req1_signed: same as requester 0, for requester 1.
- rsp_valid  output  1  product available.
- rsp_ready  input  1  consumer accepts the product.
- rsp_id  output  1  requester index the product belongs to.
- rsp_prod  output  2*WIDTH  product; two's complement if the request was signed.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE:
  - Grant is combinational. If only one valid is high, grant it. If both are high, grant the requester not granted last (the `last` pointer).
  - `reqN_ready` = 1 only for the granted requester, only in IDLE, only when `rst` = 0.
  - Handshake = valid & ready at the edge. It captures the operands, `signed`, and `id`, then moves to BUSY.
- Capture for signed requests:
  - Store operand magnitudes: |−128| = 0x80, held as unsigned WIDTH bits.
  - Store `neg` = a[MSB] ^ b[MSB].
  - Unsigned requests: `neg` = 0, operands are stored as-is.
- BUSY: WIDTH iterations of shift-add, one per cycle, on a 2*WIDTH accumulator. An iteration counter runs 0..WIDTH−1; after the last iteration the state moves to DONE.
- On entering DONE:
  - `rsp_prod` = `neg` ? −acc : acc, truncated to 2*WIDTH bits.
  - `rsp_valid` = 1; `rsp_id` = captured id.
- DONE:
  - `rsp_valid`, `rsp_prod` and `rsp_id` are held stable until `rsp_ready` = 1.
  - On that edge: `rsp_valid` → 0, `last` ← `rsp_id`, state → IDLE.
  - No requests are accepted in BUSY or DONE.
- Width rules:
  - Signed results cover −16256..16384 (WIDTH=8), so no overflow is possible in 2*WIDTH bits.
  - Unsigned maximum is 0xFE01.
- Reset:
  - State = IDLE, `rsp_valid` = 0, `rsp_prod` = 0, `rsp_id` = 0.
  - `last` = 1, so requester 0 wins the first tie.
  - Counter and accumulator = 0; both `reqN_ready` = 0 during reset.
  - Reset mid-BUSY or mid-DONE abandons the operation. No response is ever produced for it, and the requester is not re-granted automatically.
- Requester rules: a requester must hold valid and operands stable until its ready. Dropping valid before the grant is allowed and simply removes that request.

## Timing
- Accept edge ends cycle 0.
- BUSY occupies cycles 1..WIDTH.
- `rsp_valid` is high from cycle WIDTH+1 (cycle 9 for WIDTH=8).
- If `rsp_ready` is high in the first DONE cycle:
  - IDLE is in cycle WIDTH+2, and the next accept can happen there.
  - Minimum spacing between accepts is WIDTH+2 cycles.
- Back-pressure: each cycle of `rsp_ready` = 0 extends DONE by one cycle, with outputs held.
- `reqN_ready` depends combinationally on `reqN_valid`, state and `last`. There are no other combinational input-to-output paths.

## Test plan
- Reset then a single request: req0 a=0xFF, b=0xFF, signed=0 → req0_ready in cycle 0; rsp_valid in cycle 9; rsp_prod=0xFE01, rsp_id=0.
- Signed corners, issued sequentially:
  - 0xFF×0xFF signed → 0x0001.
  - 0x80×0x80 → 0x4000.
  - 0x80×0x7F → 0xC080.
  - 0x00×0x80 → 0x0000 (the −0 case).
- Both valid continuously with distinct operands, 6 transactions → grants alternate 0,1,0,1,0,1 starting with req0 after reset; each rsp_id and rsp_prod matches its requester.
- Back-pressure: rsp_ready=0 for 5 cycles in DONE → rsp_valid, rsp_prod and rsp_id are held constant; no ready is given to a waiting req1 until the cycle after rsp_ready=1.
- rst asserted in cycle 4 of BUSY → next cycle state is IDLE with rsp_valid=0 and rsp_prod=0; no response appears for the aborted request; a following req1-only request completes normally.
- Random: 2000 mixed signed/unsigned requests with random valid and rsp_ready → every accepted request gets exactly one response, in order, matching a scoreboard.
